dmem_arbiter: RTL and testbench

//  Shares the single-port data memory (DMEM) between two requesters: m0 = CPU load/store unit, m1 = debug/loader port.

---
 rtl/dmem_arbiter_pkg.sv | 24 ++
 rtl/dmem_arbiter_if.sv | 29 ++
 rtl/dmem_arbiter_rr_pick2.sv | 22 ++
 rtl/dmem_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared encodings for the DMEM arbiter.
// Holds the pointer/lock FSM state encoding, the word-alignment mask
// and the alignment helper used by the top level.
// Optional lock feature is enabled by defining DMEM_ARB_LOCK_EN.

package dmem_arbiter_pkg;

    // Pointer / ownership states. LOCKED_* are only reachable with DMEM_ARB_LOCK_EN.
    typedef enum logic [1:0] {
        LAST_M0   = 2'b00,
        LAST_M1   = 2'b01,
        LOCKED_M0 = 2'b10,
        LOCKED_M1 = 2'b11
    } arb_state_e;

    // Byte-offset bits that must be zero for a word access.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    // True when the low address bits select a whole word.
    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester's handshake bundle towards the DMEM arbiter.
// The master modport is the requester side, the slave modport the arbiter side.
// With DMEM_ARB_LOCK_EN defined the bundle carries an extra lock input.

interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req;
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
`ifdef DMEM_ARB_LOCK_EN
    logic              lock;
`endif
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;

`ifdef DMEM_ARB_LOCK_EN
    modport master (output req, wen, addr, wdata, lock, input gnt, rvalid, rdata, err);
    modport slave  (input req, wen, addr, wdata, lock, output gnt, rvalid, rdata, err);
`else
    modport master (output req, wen, addr, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, wen, addr, wdata, output gnt, rvalid, rdata, err);
`endif

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin pick, purely combinational.
// ptr names the requester granted last (0 = m0, 1 = m1); on contention
// the other requester wins.

module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    // One-hot pick: single requester wins outright, contention goes to !ptr
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port DMEM between m0 (CPU LSU) and m1 (debug/loader).
// Round-robin grant, alignment check before DMEM access, registered read return,
// one-cycle error pulse for misaligned accesses and a saturating conflict counter.
// Define DMEM_ARB_LOCK_EN to add per-master lock inputs giving exclusive ownership.

module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     m0,
    dmem_arbiter_if.slave     m1,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              dmem_wen,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [CNT_W-1:0]  conflict_cnt
);

    arb_state_e        state_r;
    arb_state_e        won_state_s;
    logic              ptr_s;
    logic              m0_lock_s;
    logic              m1_lock_s;
    logic              own0_s;
    logic              own1_s;
    logic [1:0]        req_s;
    logic [1:0]        pick_s;
    logic [1:0]        gnt_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              sel_wen_s;
    logic              sel_aligned_s;
    logic              rd_ok_s;
    logic [ADDR_W-1:0] addr_hold_r;
    logic [DATA_W-1:0] wdata_hold_r;
    logic [1:0]        rvalid_r;
    logic [1:0]        err_r;
    logic [DATA_W-1:0] rdata0_r;
    logic [DATA_W-1:0] rdata1_r;
    logic [CNT_W-1:0]  cnt_r;

`ifdef DMEM_ARB_LOCK_EN
    assign m0_lock_s = m0.lock;
    assign m1_lock_s = m1.lock;
`else
    assign m0_lock_s = 1'b0;
    assign m1_lock_s = 1'b0;
`endif

    // A lock owner keeps DMEM only while its lock stays high
    assign own0_s = (state_r == LOCKED_M0) && m0_lock_s;
    assign own1_s = (state_r == LOCKED_M1) && m1_lock_s;
    assign ptr_s  = (state_r == LAST_M1) || (state_r == LOCKED_M1);
    assign req_s  = {m1.req, m0.req};

    rr_pick2 u_pick (
        .req (req_s),
        .ptr (ptr_s),
        .gnt (pick_s)
    );

    // Final grant: an active owner masks the other master, otherwise round-robin
    always_comb begin
        gnt_s = 2'b00;
        if (own0_s) begin
            gnt_s = {1'b0, m0.req};
        end else if (own1_s) begin
            gnt_s = {m1.req, 1'b0};
        end else begin
            gnt_s = pick_s;
        end
    end

    // State implied by this cycle's winner; without a winner a released lock falls back to LAST_*
    always_comb begin
        won_state_s = state_r;
        if (gnt_s[0]) begin
            won_state_s = m0_lock_s ? LOCKED_M0 : LAST_M0;
        end else if (gnt_s[1]) begin
            won_state_s = m1_lock_s ? LOCKED_M1 : LAST_M1;
        end else if (state_r == LOCKED_M0) begin
            won_state_s = LAST_M0;
        end else if (state_r == LOCKED_M1) begin
            won_state_s = LAST_M1;
        end else begin
            won_state_s = state_r;
        end
    end

    // Pointer / ownership FSM; reset leaves m1 as last winner so m0 wins the first conflict
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= LAST_M1;
        end else begin
            case (state_r)
                LAST_M0:   state_r <= won_state_s;
                LAST_M1:   state_r <= won_state_s;
                LOCKED_M0: state_r <= own0_s ? LOCKED_M0 : won_state_s;
                LOCKED_M1: state_r <= own1_s ? LOCKED_M1 : won_state_s;
                default:   state_r <= LAST_M1;
            endcase
        end
    end

    // Route the granted master's request fields
    always_comb begin
        sel_addr_s  = m0.addr;
        sel_wdata_s = m0.wdata;
        sel_wen_s   = m0.wen;
        if (gnt_s[1]) begin
            sel_addr_s  = m1.addr;
            sel_wdata_s = m1.wdata;
            sel_wen_s   = m1.wen;
        end else begin
            sel_addr_s  = m0.addr;
            sel_wdata_s = m0.wdata;
            sel_wen_s   = m0.wen;
        end
    end

    assign sel_aligned_s = is_aligned(sel_addr_s[1:0]);
    assign rd_ok_s       = ~sel_wen_s & sel_aligned_s;

    // DMEM drive: misaligned or in-reset writes never reach DMEM (protects word 0)
    always_comb begin
        dmem_addr  = addr_hold_r;
        dmem_wdata = wdata_hold_r;
        dmem_wen   = 1'b0;
        if (|gnt_s) begin
            dmem_addr  = sel_addr_s;
            dmem_wdata = sel_wdata_s;
            dmem_wen   = sel_wen_s & sel_aligned_s & ~rst;
        end else begin
            dmem_addr  = addr_hold_r;
            dmem_wdata = wdata_hold_r;
            dmem_wen   = 1'b0;
        end
    end

    // Remember the last granted address/data so the DMEM bus is stable while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_hold_r  <= {ADDR_W{1'b0}};
            wdata_hold_r <= {DATA_W{1'b0}};
        end else if (|gnt_s) begin
            addr_hold_r  <= sel_addr_s;
            wdata_hold_r <= sel_wdata_s;
        end else begin
            addr_hold_r  <= addr_hold_r;
            wdata_hold_r <= wdata_hold_r;
        end
    end

    // Read return and error pulses, one cycle after the grant; reset kills pending pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_r <= 2'b00;
            err_r    <= 2'b00;
            rdata0_r <= {DATA_W{1'b0}};
            rdata1_r <= {DATA_W{1'b0}};
        end else begin
            rvalid_r <= gnt_s & {2{rd_ok_s}};
            err_r    <= gnt_s & {2{~sel_aligned_s}};
            if (gnt_s[0] && rd_ok_s) begin
                rdata0_r <= dmem_rdata;
            end else begin
                rdata0_r <= rdata0_r;
            end
            if (gnt_s[1] && rd_ok_s) begin
                rdata1_r <= dmem_rdata;
            end else begin
                rdata1_r <= rdata1_r;
            end
        end
    end

    // Saturating count of cycles where both masters request
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (m0.req && m1.req && !(&cnt_r)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign m0.gnt       = gnt_s[0];
    assign m1.gnt       = gnt_s[1];
    assign m0.rvalid    = rvalid_r[0];
    assign m1.rvalid    = rvalid_r[1];
    assign m0.err       = err_r[0];
    assign m1.err       = err_r[1];
    assign m0.rdata     = rdata0_r;
    assign m1.rdata     = rdata1_r;
    assign conflict_cnt = cnt_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed, table-driven bench for dmem_arbiter.
// Inputs change 1 ns after the rising edge; outputs are checked on the falling edge.
// Lock sequence is compiled in only when DMEM_ARB_LOCK_EN is defined.

module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        tb_init;
    logic [7:0]  dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_wen;
    logic [31:0] dmem_rdata;
    logic [3:0]  conflict_cnt;
    logic [31:0] mem [64];

    int total = 0;
    int bad   = 0;

    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) m0_if ();
    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) m1_if ();

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .m0           (m0_if),
        .m1           (m1_if),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_wen     (dmem_wen),
        .dmem_rdata   (dmem_rdata),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    // DMEM model: word array, synchronous write, combinational read, preload on tb_init
    always_ff @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i);
        end else if (dmem_wen) begin
            mem[dmem_addr[7:2]] <= dmem_wdata;
        end
    end
    assign dmem_rdata = mem[dmem_addr[7:2]];

    typedef struct {
        logic        rst;
        logic        r0;
        logic        w0;
        logic [7:0]  a0;
        logic [31:0] d0;
        logic        r1;
        logic        w1;
        logic [7:0]  a1;
        logic [31:0] d1;
        logic [1:0]  egnt;
        logic        ewen;
        logic [7:0]  eaddr;
        logic [1:0]  erv;
        logic [1:0]  eerr;
        logic [31:0] erd0;
        logic [31:0] erd1;
        logic [3:0]  ecnt;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s [%0d]: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic q0, input logic we0, input logic [7:0] ad0, input logic [31:0] wd0,
                         input logic q1, input logic we1, input logic [7:0] ad1, input logic [31:0] wd1);
        rst         = r;
        m0_if.req   = q0;
        m0_if.wen   = we0;
        m0_if.addr  = ad0;
        m0_if.wdata = wd0;
        m1_if.req   = q1;
        m1_if.wen   = we1;
        m1_if.addr  = ad1;
        m1_if.wdata = wd1;
    endtask

    initial begin
        //          rst   r0    w0    a0     d0            r1    w1    a1     d1            gnt    wen   addr   rv     err    rd0           rd1           cnt
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 8'h00, 32'h0,        2'b00, 1'b0, 8'h00, 2'b00, 2'b00, 32'h0,        32'h0,        4'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h04, 32'h0,        1'b1, 1'b0, 8'h08, 32'h0,        2'b01, 1'b0, 8'h04, 2'b00, 2'b00, 32'h0,        32'h0,        4'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h04, 32'h0,        1'b1, 1'b0, 8'h08, 32'h0,        2'b10, 1'b0, 8'h08, 2'b01, 2'b00, 32'h10000001, 32'h0,        4'd1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h04, 32'h0,        1'b1, 1'b0, 8'h08, 32'h0,        2'b01, 1'b0, 8'h04, 2'b10, 2'b00, 32'h10000001, 32'h10000002, 4'd2};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h04, 32'h0,        1'b1, 1'b0, 8'h08, 32'h0,        2'b10, 1'b0, 8'h08, 2'b01, 2'b00, 32'h10000001, 32'h10000002, 4'd3};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 8'h00, 32'h0,        2'b00, 1'b0, 8'h08, 2'b10, 2'b00, 32'h10000001, 32'h10000002, 4'd4};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 1'b0, 8'h00, 32'h0,        2'b01, 1'b1, 8'h10, 2'b00, 2'b00, 32'h10000001, 32'h10000002, 4'd4};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h10, 32'h0,        1'b0, 1'b0, 8'h00, 32'h0,        2'b01, 1'b0, 8'h10, 2'b00, 2'b00, 32'h10000001, 32'h10000002, 4'd4};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 32'h0,        1'b1, 1'b1, 8'h06, 32'hCAFEF00D, 2'b10, 1'b0, 8'h06, 2'b01, 2'b00, 32'hDEADBEEF, 32'h10000002, 4'd4};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 32'h0,        1'b1, 1'b0, 8'h00, 32'h0,        2'b10, 1'b0, 8'h00, 2'b00, 2'b10, 32'hDEADBEEF, 32'h10000002, 4'd4};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h06, 32'h0,        1'b0, 1'b0, 8'h00, 32'h0,        2'b01, 1'b0, 8'h06, 2'b10, 2'b00, 32'hDEADBEEF, 32'h10000000, 4'd4};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 8'h00, 32'h0,        2'b00, 1'b0, 8'h06, 2'b00, 2'b01, 32'hDEADBEEF, 32'h10000000, 4'd4};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 8'h0C, 32'h0,        1'b1, 1'b1, 8'h0C, 32'h12345678, 2'b10, 1'b1, 8'h0C, 2'b00, 2'b00, 32'hDEADBEEF, 32'h10000000, 4'd4};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 8'h0C, 32'h0,        1'b0, 1'b0, 8'h00, 32'h0,        2'b01, 1'b0, 8'h0C, 2'b00, 2'b00, 32'hDEADBEEF, 32'h10000000, 4'd5};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 8'h00, 32'h0,        2'b00, 1'b0, 8'h0C, 2'b01, 2'b00, 32'h12345678, 32'h10000000, 4'd5};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 8'h20, 32'hBADC0FFE, 1'b0, 1'b0, 8'h00, 32'h0,        2'b01, 1'b0, 8'h20, 2'b00, 2'b00, 32'h12345678, 32'h10000000, 4'd5};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 8'h00, 32'h0,        2'b00, 1'b0, 8'h00, 2'b00, 2'b00, 32'h0,        32'h0,        4'd0};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 8'h20, 32'h0,        1'b0, 1'b0, 8'h00, 32'h0,        2'b01, 1'b0, 8'h20, 2'b00, 2'b00, 32'h0,        32'h0,        4'd0};
        vecs[18] = '{1'b1, 1'b1, 1'b0, 8'h08, 32'h0,        1'b0, 1'b0, 8'h00, 32'h0,        2'b01, 1'b0, 8'h08, 2'b01, 2'b00, 32'h10000008, 32'h0,        4'd0};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 8'h00, 32'h0,        1'b0, 1'b0, 8'h00, 32'h0,        2'b00, 1'b0, 8'h00, 2'b00, 2'b00, 32'h0,        32'h0,        4'd0};

        tb_init = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
`ifdef DMEM_ARB_LOCK_EN
        m0_if.lock = 1'b0;
        m1_if.lock = 1'b0;
`endif

        // Table: reset state, alternating conflicts, write/read, misalignment, rst mid-operation
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            tb_init = 1'b0;
            drive(vecs[i].rst, vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
                  vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
            @(negedge clk);
            chk("gnt",    i, {30'd0, m1_if.gnt, m0_if.gnt},       {30'd0, vecs[i].egnt});
            chk("wen",    i, {31'd0, dmem_wen},                   {31'd0, vecs[i].ewen});
            chk("addr",   i, {24'd0, dmem_addr},                  {24'd0, vecs[i].eaddr});
            chk("rvalid", i, {30'd0, m1_if.rvalid, m0_if.rvalid}, {30'd0, vecs[i].erv});
            chk("err",    i, {30'd0, m1_if.err, m0_if.err},       {30'd0, vecs[i].eerr});
            chk("rdata0", i, m0_if.rdata,                         vecs[i].erd0);
            chk("rdata1", i, m1_if.rdata,                         vecs[i].erd1);
            chk("cnt",    i, {28'd0, conflict_cnt},               {28'd0, vecs[i].ecnt});
        end

        // Word 0 and word 0x20 contents survived the dropped writes
        chk("mem_w0",   0, mem[0], 32'h10000000);
        chk("mem_w20",  8, mem[8], 32'h10000008);
        chk("mem_w10",  4, mem[4], 32'hDEADBEEF);

        // Saturation: 20 cycles of continuous conflict on a 4-bit counter
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            drive(1'b0, 1'b1, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h00, 32'h0);
            @(negedge clk);
            if (k == 14) chk("cnt_sat", k, {28'd0, conflict_cnt}, 32'd14);
            else if (k == 15) chk("cnt_sat", k, {28'd0, conflict_cnt}, 32'd15);
            else if (k == 19) chk("cnt_sat", k, {28'd0, conflict_cnt}, 32'd15);
        end
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        chk("cnt_sat", 20, {28'd0, conflict_cnt}, 32'd15);

`ifdef DMEM_ARB_LOCK_EN
        // Lock: m0 goes first, then m1 locks and keeps DMEM for 3 cycles against m0
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 1'b0, 8'h04, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        chk("lock_gnt", 0, {30'd0, m1_if.gnt, m0_if.gnt}, 32'd1);
        for (int c = 1; c < 5; c++) begin
            @(posedge clk);
            #1;
            drive(1'b0, 1'b1, 1'b0, 8'h04, 32'h0, 1'b1, 1'b0, 8'h08, 32'h0);
            m1_if.lock = (c < 4) ? 1'b1 : 1'b0;
            @(negedge clk);
            chk("lock_gnt", c, {30'd0, m1_if.gnt, m0_if.gnt}, (c < 4) ? 32'd2 : 32'd1);
        end
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
        m1_if.lock = 1'b0;
        @(negedge clk);
        chk("lock_cnt", 5, {28'd0, conflict_cnt}, 32'd4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
